// File: rtl/gray_ptr_sync_mc_if.sv
// Bundle of pointer inputs and synchronized monitor outputs shared between the
// read-side logic and the multi-channel Gray pointer synchronizer.
interface gray_ptr_sync_mc_if #(
  parameter int ASIZE = 4,
  parameter int NCH   = 1
);
  localparam int PW = ASIZE + 1;

  logic [NCH*PW-1:0] wptr;
  logic [NCH-1:0]    err_clr;
  logic [NCH*PW-1:0] s_wptr;
  logic [NCH*PW-1:0] s_wbin;
  logic [NCH-1:0]    s_chg;
  logic [NCH-1:0]    s_err;
  logic              s_rdy;

  modport master (
    output wptr, err_clr,
    input  s_wptr, s_wbin, s_chg, s_err, s_rdy
  );

  modport slave (
    input  wptr, err_clr,
    output s_wptr, s_wbin, s_chg, s_err, s_rdy
  );
endinterface

// File: rtl/gray_ptr_sync_mc.sv
// Multi-channel Gray pointer synchronizer into rclk: NSTAGE flop chain per channel
// followed by a registered monitor giving binary pointer, change strobe and jump error.
module gray_ptr_sync_mc #(
  parameter int ASIZE  = 4,
  parameter int NSTAGE = 2,
  parameter int NCH    = 1
) (
  input  logic               rclk,
  input  logic               rrst,
  gray_ptr_sync_mc_if.slave  bus
);
  localparam int PW = ASIZE + 1;
  localparam int W  = NCH * PW;
  localparam logic [2:0] RDY_N = 3'(NSTAGE + 1);

  if (NSTAGE < 2 || NSTAGE > 4) begin : g_bad_nstage
    $error("gray_ptr_sync_mc: NSTAGE must be in 2..4");
  end

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // More than one bit set iff clearing the lowest set bit leaves something.
  function automatic logic multi_bit(input logic [PW-1:0] d);
    return (d & (d - PW'(1))) != '0;
  endfunction

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync_p0;
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync_p1;
  logic [W-1:0]   sync_last;
  logic [W-1:0]   prev;
  logic [W-1:0]   wbin;
  logic [NCH-1:0] chg;
  logic [NCH-1:0] err;
  logic           rdy;
  logic [2:0]     rdy_cnt;

  if (NSTAGE == 2) begin : g_tail_none
    assign sync_last = sync_p1;
  end else begin : g_tail
    logic [W-1:0] sync_tail [NSTAGE-2];

    // Extra chain stages beyond the two metastability-hardened flops
    always_ff @(posedge rclk) begin
      if (rrst) begin
        for (int i = 0; i < NSTAGE - 2; i++) sync_tail[i] <= '0;
      end else begin
        sync_tail[0] <= sync_p1;
        for (int i = 1; i < NSTAGE - 2; i++) sync_tail[i] <= sync_tail[i-1];
      end
    end

    assign sync_last = sync_tail[NSTAGE-3];
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev    <= '0;
      wbin    <= '0;
      chg     <= '0;
      err     <= '0;
      rdy     <= 1'b0;
      rdy_cnt <= '0;
    end else begin
      sync_p0 <= bus.wptr;
      sync_p1 <= sync_p0;

      // rdy is held off until the chain and prev have flushed to the live pointer
      if (rdy_cnt != RDY_N) rdy_cnt <= rdy_cnt + 3'd1;
      if (rdy_cnt == RDY_N) rdy <= 1'b1;

      // Monitor stage
      prev <= sync_last;
      for (int k = 0; k < NCH; k++) begin
        wbin[k*PW +: PW] <= gray2bin(sync_last[k*PW +: PW]);
        chg[k] <= rdy && (sync_last[k*PW +: PW] != prev[k*PW +: PW]);
        if (rdy && multi_bit(sync_last[k*PW +: PW] ^ prev[k*PW +: PW])) err[k] <= 1'b1;
        else if (bus.err_clr[k]) err[k] <= 1'b0;
      end
    end
  end

  assign bus.s_wptr = sync_last;
  assign bus.s_wbin = wbin;
  assign bus.s_chg  = chg;
  assign bus.s_err  = err;
  assign bus.s_rdy  = rdy;
endmodule
